// File: rtl/proc_ctrl_pkg.sv
// Shared types for the processor control blocks.
// Injected-op encodings and interrupt sequencer states.
package proc_ctrl_pkg;

    typedef enum logic [1:0] {
        NOP  = 2'd0,
        PUSH = 2'd1,
        READ = 2'd2
    } inject_op_t;

    typedef enum logic [2:0] {
        IDLE,
        DRAIN,
        PUSH_HI,
        PUSH_LO,
        VEC_HI,
        VEC_LO,
        WAIT_VEC,
        REDIRECT
    } int_state_t;

    localparam logic [15:0] VECTOR_ADDR_DEFAULT = 16'h0000;

endpackage

// File: rtl/interrupt_sequencer_if.sv
// Injection bus between the sequencer and decode/memory.
// master drives injected ops; slave returns read data.
interface interrupt_sequencer_if;
    import proc_ctrl_pkg::*;

    logic        inject_valid;
    inject_op_t  inject_op;
    logic [15:0] inject_data;
    logic [15:0] mem_rdata;
    logic        mem_rdata_valid;

    modport master (
        output inject_valid,
        output inject_op,
        output inject_data,
        input  mem_rdata,
        input  mem_rdata_valid
    );

    modport slave (
        input  inject_valid,
        input  inject_op,
        input  inject_data,
        output mem_rdata,
        output mem_rdata_valid
    );

endinterface

// File: rtl/int_pending_latch.sv
// Rising-edge detector with a one-deep pending flag.
// Clear wins over a coincident set.
module int_pending_latch (
    input  logic clk,
    input  logic rst,
    input  logic sig,
    input  logic clr,
    output logic pending
);

    logic prev;

    // Sample the request and hold one pending edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev    <= 1'b0;
            pending <= 1'b0;
        end else begin
            prev <= sig;
            if (clr)
                pending <= 1'b0;
            else if (sig && !prev)
                pending <= 1'b1;
        end
    end

endmodule

// File: rtl/interrupt_sequencer.sv
// Interrupt entry/return sequencer: drain, push PC,
// fetch vector, redirect fetch; holds the flag shadow.
module interrupt_sequencer
    import proc_ctrl_pkg::*;
#(
    parameter int          DRAIN_CYCLES = 3,
    parameter logic [15:0] VECTOR_ADDR  = VECTOR_ADDR_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  interrupt_signal,
    input  logic                  instr_boundary,
    input  logic                  branch_pending,
    input  logic [31:0]           pc_next,
    input  logic [2:0]            flags,
    input  logic                  rti_retire,
    interrupt_sequencer_if.master bus,
    output logic                  stall_fetch,
    output logic                  pc_load,
    output logic [31:0]           pc_load_value,
    output logic                  flags_restore,
    output logic [2:0]            flags_shadow,
    output logic                  in_service
);

    localparam int CW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [CW-1:0] DRAIN_LOAD = CW'(DRAIN_CYCLES - 1);

    int_state_t  state;
    logic [CW-1:0] drain_cnt;
    logic [1:0]  rd_cnt;
    logic [31:0] saved_pc;
    logic [31:0] vec;
    logic        pending;
    logic        entry;
    logic        vec_win;
    logic        take;
    logic        vec_done;

    int_pending_latch u_pending (
        .clk     (clk),
        .rst     (rst),
        .sig     (interrupt_signal),
        .clr     (pc_load),
        .pending (pending)
    );

    assign entry = pending && !in_service
                && instr_boundary && !branch_pending;
    assign vec_win = (state == VEC_HI) || (state == VEC_LO)
                  || (state == WAIT_VEC);
    assign take = vec_win && bus.mem_rdata_valid
               && (rd_cnt != 2'd2);
    assign vec_done = (rd_cnt == 2'd2)
                   || ((rd_cnt == 2'd1) && take);

    // Sequencer state, vector capture and flag shadow
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            drain_cnt     <= '0;
            rd_cnt        <= 2'd0;
            saved_pc      <= '0;
            vec           <= '0;
            flags_shadow  <= '0;
            in_service    <= 1'b0;
            flags_restore <= 1'b0;
        end else begin
            flags_restore <= 1'b0;
            if (rti_retire && in_service) begin
                in_service    <= 1'b0;
                flags_restore <= 1'b1;
            end
            if (take) begin
                rd_cnt <= rd_cnt + 2'd1;
                if (rd_cnt == 2'd0)
                    vec[31:16] <= bus.mem_rdata;
                else
                    vec[15:0] <= bus.mem_rdata;
            end
            unique case (state)
                IDLE: begin
                    if (entry) begin
                        state        <= DRAIN;
                        drain_cnt    <= DRAIN_LOAD;
                        rd_cnt       <= 2'd0;
                        saved_pc     <= pc_next;
                        flags_shadow <= flags;
                        in_service   <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (drain_cnt == '0)
                        state <= PUSH_HI;
                    else
                        drain_cnt <= drain_cnt - 1'b1;
                end
                PUSH_HI:  state <= PUSH_LO;
                PUSH_LO:  state <= VEC_HI;
                VEC_HI:   state <= VEC_LO;
                VEC_LO:   state <= WAIT_VEC;
                WAIT_VEC: if (vec_done) state <= REDIRECT;
                REDIRECT: state <= IDLE;
                default:  state <= IDLE;
            endcase
        end
    end

    assign stall_fetch      = (state != IDLE);
    assign bus.inject_valid = (state != IDLE);
    assign pc_load          = (state == REDIRECT);
    assign pc_load_value    = pc_load ? vec : 32'h0;

    // Decode the injected op and its payload from state
    always_comb begin
        bus.inject_op   = NOP;
        bus.inject_data = 16'h0;
        unique case (state)
            PUSH_HI: begin
                bus.inject_op   = PUSH;
                bus.inject_data = saved_pc[31:16];
            end
            PUSH_LO: begin
                bus.inject_op   = PUSH;
                bus.inject_data = saved_pc[15:0];
            end
            VEC_HI: begin
                bus.inject_op   = READ;
                bus.inject_data = VECTOR_ADDR;
            end
            VEC_LO: begin
                bus.inject_op   = READ;
                bus.inject_data = VECTOR_ADDR + 16'd1;
            end
            default: begin
                bus.inject_op   = NOP;
                bus.inject_data = 16'h0;
            end
        endcase
    end

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Randomized bench for interrupt_sequencer against a
// sequence-position reference model plus directed cases.
module tb_interrupt_sequencer;
    import proc_ctrl_pkg::*;

    localparam int          DC = 3;
    localparam logic [15:0] VA = 16'h0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        interrupt_signal;
    logic        instr_boundary;
    logic        branch_pending;
    logic [31:0] pc_next;
    logic [2:0]  flags;
    logic        rti_retire;
    logic        stall_fetch;
    logic        pc_load;
    logic [31:0] pc_load_value;
    logic        flags_restore;
    logic [2:0]  flags_shadow;
    logic        in_service;

    interrupt_sequencer_if bus ();

    interrupt_sequencer #(
        .DRAIN_CYCLES (DC),
        .VECTOR_ADDR  (VA)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .interrupt_signal (interrupt_signal),
        .instr_boundary   (instr_boundary),
        .branch_pending   (branch_pending),
        .pc_next          (pc_next),
        .flags            (flags),
        .rti_retire       (rti_retire),
        .bus              (bus),
        .stall_fetch      (stall_fetch),
        .pc_load          (pc_load),
        .pc_load_value    (pc_load_value),
        .flags_restore    (flags_restore),
        .flags_shadow     (flags_shadow),
        .in_service       (in_service)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h",
                     tag, obs, exp);
        end
    endtask

    // Reference model: position in the entry sequence
    // (-1 = idle), request/service flags, captured words.
    bit          m_prev, m_pend, m_svc, m_restore, m_redir;
    int          m_pos, m_nv;
    logic [31:0] m_vec, m_pc;
    logic [2:0]  m_shadow;

    // Memory responder schedule, set when entry is predicted.
    int          cyc = 0;
    int          v1 = -1, v2 = -1;
    logic [15:0] w1, w2, fw1, fw2;
    int          lat = 3, gap = 0;

    // Observation log for directed checks.
    bit          prev_stall = 1'b0;
    int          drain_c = -1;
    logic [15:0] push_q[$];
    logic [15:0] read_q[$];

    task automatic model_reset();
        m_prev = 0; m_pend = 0; m_svc = 0;
        m_restore = 0; m_redir = 0;
        m_pos = -1; m_nv = 0;
        m_vec = '0; m_pc = '0; m_shadow = '0;
        v1 = -1; v2 = -1;
    endtask

    task automatic exp_check();
        bit          act;
        logic [1:0]  eop;
        logic [15:0] ed;
        act = (m_pos >= 0);
        eop = 2'd0;
        ed  = 16'h0;
        if (act && !m_redir) begin
            if (m_pos == DC) begin
                eop = 2'd1; ed = m_pc[31:16];
            end else if (m_pos == DC + 1) begin
                eop = 2'd1; ed = m_pc[15:0];
            end else if (m_pos == DC + 2) begin
                eop = 2'd2; ed = VA;
            end else if (m_pos == DC + 3) begin
                eop = 2'd2; ed = VA + 16'd1;
            end
        end
        check("stall", 32'(stall_fetch), 32'(act));
        check("inj_valid", 32'(bus.inject_valid), 32'(act));
        check("inj_op", 32'(bus.inject_op), 32'(eop));
        check("inj_data", 32'(bus.inject_data), 32'(ed));
        check("pc_load", 32'(pc_load), 32'(m_redir));
        check("pc_val", pc_load_value,
              m_redir ? m_vec : 32'h0);
        check("frestore", 32'(flags_restore),
              32'(m_restore));
        check("fshadow", 32'(flags_shadow), 32'(m_shadow));
        check("in_svc", 32'(in_service), 32'(m_svc));
    endtask

    // Advance the model across the coming clock edge.
    task automatic model_step();
        bit edge_s, npend, nsvc, nrest;
        int nv;
        edge_s = interrupt_signal && !m_prev;
        nrest  = rti_retire && m_svc;
        nsvc   = m_svc && !rti_retire;
        npend  = m_pend | edge_s;
        nv     = m_nv;
        if (m_pos >= DC + 2 && !m_redir
            && bus.mem_rdata_valid && m_nv < 2) begin
            if (m_nv == 0) m_vec[31:16] = bus.mem_rdata;
            else           m_vec[15:0]  = bus.mem_rdata;
            nv = m_nv + 1;
        end
        if (m_redir) begin
            m_redir = 0;
            m_pos   = -1;
            npend   = 0;
        end else if (m_pos >= 0) begin
            if (m_pos >= DC + 4 && nv >= 2) m_redir = 1;
            m_pos++;
        end else if (m_pend && !m_svc && instr_boundary
                     && !branch_pending) begin
            m_pos    = 0;
            m_pc     = pc_next;
            m_shadow = flags;
            nsvc     = 1;
            nv       = 0;
            v1 = cyc + 1 + DC + 2 + lat;
            v2 = v1 + 1 + gap;
            w1 = fw1;
            w2 = fw2;
        end
        m_pend    = npend;
        m_svc     = nsvc;
        m_restore = nrest;
        m_nv      = nv;
        m_prev    = interrupt_signal;
    endtask

    task automatic cycle();
        if (cyc == v1) begin
            bus.mem_rdata_valid = 1'b1;
            bus.mem_rdata       = w1;
        end else if (cyc == v2) begin
            bus.mem_rdata_valid = 1'b1;
            bus.mem_rdata       = w2;
        end else begin
            bus.mem_rdata = 16'($urandom);
            bus.mem_rdata_valid = (m_pos < DC + 2)
                && ($urandom_range(0, 7) == 0);
        end
        model_step();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        exp_check();
        if (stall_fetch && !prev_stall) drain_c = cyc;
        prev_stall = stall_fetch;
        if (bus.inject_op == PUSH)
            push_q.push_back(bus.inject_data);
        if (bus.inject_op == READ)
            read_q.push_back(bus.inject_data);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        #1;
        exp_check();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        rst = 1'b0;
        prev_stall = 1'b0;
        exp_check();
    endtask

    task automatic finish_seq(output int pl_c,
                              output logic [31:0] pl_v);
        int pl_n;
        pl_n = 0;
        pl_c = -1;
        pl_v = '0;
        for (int i = 0; i < 60 && (pl_n == 0 || stall_fetch);
             i++) begin
            cycle();
            if (pc_load) begin
                pl_n++;
                pl_c = cyc;
                pl_v = pc_load_value;
            end
        end
        check("pcload_pulses", 32'(pl_n), 32'd1);
    endtask

    task automatic rti_pulse();
        rti_retire = 1'b1;
        cycle();
        rti_retire = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, pl_c, r;
        logic [31:0] pl_v;
        bit saw;

        rst = 1'b1;
        interrupt_signal = 1'b0;
        instr_boundary = 1'b1;
        branch_pending = 1'b0;
        pc_next = '0;
        flags = '0;
        rti_retire = 1'b0;
        bus.mem_rdata = '0;
        bus.mem_rdata_valid = 1'b0;
        fw1 = '0; fw2 = '0;
        model_reset();
        @(negedge clk);
        do_reset();
        check("rst_stall", 32'(stall_fetch), 32'd0);
        check("rst_svc", 32'(in_service), 32'd0);
        check("rst_pcl", 32'(pc_load), 32'd0);

        // Basic entry
        pc_next = 32'h0001_0020;
        flags = 3'b101;
        fw1 = 16'h0000; fw2 = 16'h0100;
        lat = 3; gap = 0;
        push_q.delete(); read_q.delete();
        interrupt_signal = 1'b1;
        t0 = cyc;
        cycle();
        interrupt_signal = 1'b0;
        finish_seq(pl_c, pl_v);
        check("entry_lat", 32'(drain_c - t0), 32'd2);
        check("push_n", 32'(push_q.size()), 32'd2);
        check("read_n", 32'(read_q.size()), 32'd2);
        if (push_q.size() == 2) begin
            check("push_hi", 32'(push_q[0]), 32'h0001);
            check("push_lo", 32'(push_q[1]), 32'h0020);
        end
        if (read_q.size() == 2) begin
            check("read_hi", 32'(read_q[0]), 32'h0000);
            check("read_lo", 32'(read_q[1]), 32'h0001);
        end
        check("redir_lat", 32'(pl_c - drain_c), 32'd10);
        check("vector", pl_v, 32'h0000_0100);
        check("shadow", 32'(flags_shadow), 32'd5);

        // Masking and return
        interrupt_signal = 1'b1;
        cycle();
        interrupt_signal = 1'b0;
        saw = 0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            if (stall_fetch) saw = 1;
        end
        check("masked", 32'(saw), 32'd0);
        flags = 3'b010;
        rti_pulse();
        check("restore", 32'(flags_restore), 32'd1);
        check("restore_val", 32'(flags_shadow), 32'd5);
        check("svc_clr", 32'(in_service), 32'd0);
        cycle();
        check("reenter", 32'(stall_fetch), 32'd1);
        finish_seq(pl_c, pl_v);
        rti_pulse();
        cycle();

        // Deferral by branch_pending
        branch_pending = 1'b1;
        interrupt_signal = 1'b1;
        cycle();
        interrupt_signal = 1'b0;
        check("defer0", 32'(stall_fetch), 32'd0);
        for (int i = 1; i < 4; i++) begin
            cycle();
            check("defer", 32'(stall_fetch), 32'd0);
        end
        branch_pending = 1'b0;
        cycle();
        check("defer_go", 32'(stall_fetch), 32'd1);
        finish_seq(pl_c, pl_v);

        // Same-cycle RTI and edge
        rti_retire = 1'b1;
        interrupt_signal = 1'b1;
        cycle();
        rti_retire = 1'b0;
        interrupt_signal = 1'b0;
        check("same_svc", 32'(in_service), 32'd0);
        check("same_idle", 32'(stall_fetch), 32'd0);
        cycle();
        check("same_drain", 32'(stall_fetch), 32'd1);
        finish_seq(pl_c, pl_v);
        rti_pulse();

        // Reset in PUSH_LO
        interrupt_signal = 1'b1;
        cycle();
        interrupt_signal = 1'b0;
        for (int i = 0; i < 20 && m_pos != DC + 1; i++)
            cycle();
        check("at_push_lo", 32'(bus.inject_op), 32'(PUSH));
        do_reset();
        check("rr_stall", 32'(stall_fetch), 32'd0);
        check("rr_op", 32'(bus.inject_op), 32'd0);
        check("rr_data", 32'(bus.inject_data), 32'd0);
        check("rr_svc", 32'(in_service), 32'd0);
        saw = 0;
        for (int i = 0; i < 15; i++) begin
            cycle();
            if (pc_load || flags_restore) saw = 1;
        end
        check("rr_nopulse", 32'(saw), 32'd0);

        // Late vector data
        lat = 6; gap = 2;
        fw1 = 16'hBEEF; fw2 = 16'h1234;
        interrupt_signal = 1'b1;
        cycle();
        interrupt_signal = 1'b0;
        finish_seq(pl_c, pl_v);
        check("late_lat", 32'(pl_c - v2), 32'd1);
        check("late_vec", pl_v, 32'hBEEF_1234);
        rti_pulse();

        // Randomized traffic
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 5) == 0)
                interrupt_signal = ~interrupt_signal;
            instr_boundary = ($urandom_range(0, 3) != 0);
            branch_pending = ($urandom_range(0, 3) == 0);
            rti_retire = ($urandom_range(0, 19) == 0);
            pc_next = $urandom;
            flags = 3'($urandom);
            fw1 = 16'($urandom);
            fw2 = 16'($urandom);
            lat = $urandom_range(3, 8);
            gap = $urandom_range(0, 3);
            r = $urandom_range(0, 399);
            if (r == 0) do_reset();
            else        cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
